// File: rtl/uart_cmd_pkg.sv
// Command codes, ASCII constants and FSM state type shared by the UART hex
// encoder and decoder stages, so both ends agree on the command encoding.
package uart_cmd_pkg;

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_ADDR  = 2'b10;
    localparam logic [1:0] CMD_SYNC  = 2'b11;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_LC_A  = 8'h61;
    localparam logic [7:0] ASCII_LC_F  = 8'h66;
    localparam logic [7:0] ASCII_LC_R  = 8'h72;
    localparam logic [7:0] ASCII_LC_S  = 8'h73;
    localparam logic [7:0] ASCII_LC_W  = 8'h77;
    // OR-ing this bit into an ASCII letter folds it to lower case
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    typedef enum logic [1:0] {IDLE, DIGITS, PEND} dec_state_t;

    // WRITE and ADDR carry a payload; READ and SYNC must arrive bare
    function automatic logic cmd_needs_data(input logic [1:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_ADDR);
    endfunction

endpackage

// File: rtl/hex_ascii_to_nibble.sv
// Combinational ASCII byte classifier: hex digit, command letter, line
// terminator or space, with the decoded nibble / command code.
module hex_ascii_to_nibble
    import uart_cmd_pkg::*;
(
    input  logic [7:0] rx_byte,
    output logic       is_hex,
    output logic       is_cmd,
    output logic       is_term,
    output logic       is_space,
    output logic [3:0] nib,
    output logic [1:0] cmd
);

    logic [7:0] lc;

    always_comb begin
        lc       = rx_byte | ASCII_CASE_BIT;
        is_hex   = 1'b0;
        is_cmd   = 1'b0;
        nib      = 4'h0;
        cmd      = CMD_READ;
        is_term  = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);
        is_space = (rx_byte == ASCII_SPACE);

        if (rx_byte >= ASCII_0 && rx_byte <= ASCII_9) begin
            is_hex = 1'b1;
            nib    = rx_byte[3:0];
        end else if (lc >= ASCII_LC_A && lc <= ASCII_LC_F) begin
            // 'a'..'f' have low nibble 1..6, so +9 gives 10..15
            is_hex = 1'b1;
            nib    = lc[3:0] + 4'd9;
        end

        case (lc)
            ASCII_LC_R: begin is_cmd = 1'b1; cmd = CMD_READ;  end
            ASCII_LC_W: begin is_cmd = 1'b1; cmd = CMD_WRITE; end
            ASCII_LC_A: begin is_cmd = 1'b1; cmd = CMD_ADDR;  end
            ASCII_LC_S: begin is_cmd = 1'b1; cmd = CMD_SYNC;  end
            default:    ;
        endcase
    end

endmodule

// File: rtl/uart_hex_cmd_decoder.sv
// Assembles ASCII frames "<cmd><hex digits><CR|LF>" from the UART RX into
// {cmd, data} command words; malformed or stalled frames are dropped with o_err.
module uart_hex_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int NIBBLES     = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_rx_stb,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_busy,
    output logic                    o_stb,
    output logic [4*NIBBLES+1:0]    o_word,
    output logic                    o_wb_we,
    output logic                    o_err,
    output logic                    o_dw_busy
);

    localparam int DATA_W = 4 * NIBBLES;
    localparam int CNT_W  = $clog2(NIBBLES + 1);

    dec_state_t         state;
    logic [1:0]         cmd_r;
    logic [DATA_W-1:0]  acc;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        to_cnt;

    logic               is_hex;
    logic               is_cmd;
    logic               is_term;
    logic               is_space;
    logic [3:0]         nib;
    logic [1:0]         dec_cmd;

    logic               frame_ok;
    logic               timeout_hit;

    hex_ascii_to_nibble u_classify (
        .rx_byte  (i_rx_data),
        .is_hex   (is_hex),
        .is_cmd   (is_cmd),
        .is_term  (is_term),
        .is_space (is_space),
        .nib      (nib),
        .cmd      (dec_cmd)
    );

    always_comb begin
        frame_ok    = cmd_needs_data(cmd_r) ? (cnt != '0) : (cnt == '0);
        timeout_hit = (TIMEOUT_CYC != 0) && !i_rx_stb &&
                      (to_cnt == 32'(TIMEOUT_CYC - 1));
    end

    assign o_dw_busy = (state == PEND);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            cmd_r   <= CMD_READ;
            acc     <= '0;
            cnt     <= '0;
            to_cnt  <= '0;
            o_stb   <= 1'b0;
            o_word  <= '0;
            o_wb_we <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_stb <= 1'b0;
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Stray terminators are absorbed silently (second half of CR+LF)
                    if (i_rx_stb && !is_space) begin
                        if (is_cmd) begin
                            cmd_r  <= dec_cmd;
                            acc    <= '0;
                            cnt    <= '0;
                            to_cnt <= '0;
                            state  <= DIGITS;
                        end else if (!is_term) begin
                            o_err <= 1'b1;
                        end
                    end
                end
                DIGITS: begin
                    if (i_rx_stb) begin
                        to_cnt <= '0;
                        // 'A'..'F' are hex here, so only R/W/S can restart a frame
                        if (!is_space) begin
                            if (is_hex) begin
                                if (cnt == CNT_W'(NIBBLES)) begin
                                    o_err <= 1'b1;
                                    state <= IDLE;
                                end else begin
                                    acc <= {acc[DATA_W-5:0], nib};
                                    cnt <= cnt + 1'b1;
                                end
                            end else if (is_term) begin
                                if (frame_ok) begin
                                    state <= PEND;
                                end else begin
                                    o_err <= 1'b1;
                                    state <= IDLE;
                                end
                            end else if (is_cmd) begin
                                o_err <= 1'b1;
                                cmd_r <= dec_cmd;
                                acc   <= '0;
                                cnt   <= '0;
                            end else begin
                                o_err <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end else if (timeout_hit) begin
                        o_err  <= 1'b1;
                        to_cnt <= '0;
                        state  <= IDLE;
                    end else if (TIMEOUT_CYC != 0) begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                PEND: begin
                    if (i_rx_stb) begin
                        o_err <= 1'b1;
                    end
                    if (!i_busy) begin
                        o_stb   <= 1'b1;
                        o_word  <= {cmd_r, acc};
                        o_wb_we <= (cmd_r == CMD_WRITE);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_cmd_decoder.sv
// Directed bench: expected words are queued at stimulus time and a negedge
// monitor pops and compares them whenever the decoder strobes a word out.
module tb_uart_hex_cmd_decoder;

    typedef struct packed {
        logic [33:0] word;
        logic        we;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_rx_stb = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_busy = 1'b0;
    logic        o_stb;
    logic [33:0] o_word;
    logic        o_wb_we;
    logic        o_err;
    logic        o_dw_busy;

    int   checks = 0;
    int   failures = 0;
    int   err_cnt = 0;
    int   stb_cnt = 0;
    int   e0;
    int   s0;
    exp_t exp_q[$];

    uart_hex_cmd_decoder #(.NIBBLES(8), .TIMEOUT_CYC(16)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_rx_stb  (i_rx_stb),
        .i_rx_data (i_rx_data),
        .i_busy    (i_busy),
        .o_stb     (o_stb),
        .o_word    (o_word),
        .o_wb_we   (o_wb_we),
        .o_err     (o_err),
        .o_dw_busy (o_dw_busy)
    );

    always #5 i_clk = ~i_clk;

    // Monitor: counts error pulses and checks every output word against the queue
    always @(negedge i_clk) begin
        exp_t e;
        if (o_err) err_cnt = err_cnt + 1;
        if (o_stb) begin
            stb_cnt = stb_cnt + 1;
            checks  = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_stb actual word=%h we=%b required no strobe", o_word, o_wb_we);
            end else begin
                e = exp_q.pop_front();
                if (o_word !== e.word || o_wb_we !== e.we) begin
                    failures = failures + 1;
                    $display("FAIL word actual=%h/%b required=%h/%b", o_word, o_wb_we, e.word, e.we);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // One-cycle strobe followed by one idle cycle; called just after a posedge
    task automatic send_byte(input logic [7:0] b);
        i_rx_stb  = 1'b1;
        i_rx_data = b;
        @(posedge i_clk);
        #1;
        i_rx_stb = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic expect_word(input logic [33:0] w, input logic we);
        exp_t e;
        e.word = w;
        e.we   = we;
        exp_q.push_back(e);
    endtask

    initial begin
        idle(3);
        check("reset_stb", o_stb, 0);
        check("reset_word", o_word, 0);
        check("reset_we", o_wb_we, 0);
        check("reset_err", o_err, 0);
        check("reset_dw_busy", o_dw_busy, 0);
        i_reset = 1'b0;
        idle(1);

        // Full 8-digit write
        e0 = err_cnt; s0 = stb_cnt;
        expect_word(34'h1_1234_ABCD, 1'b1);
        send_str("W1234abcd");
        send_byte(8'h0A);
        idle(2);
        check("t1_err_none", err_cnt - e0, 0);
        check("t1_one_stb", stb_cnt - s0, 1);

        // ADDR with CR+LF, then bare READ, then lowercase write with spaces
        e0 = err_cnt;
        expect_word(34'h2_0000_001F, 1'b0);
        send_str("A1f");
        send_byte(8'h0D);
        send_byte(8'h0A);
        expect_word(34'h0_0000_0000, 1'b0);
        send_str("R");
        send_byte(8'h0A);
        expect_word(34'h1_0000_00FF, 1'b1);
        send_str("w 00 ff");
        send_byte(8'h0D);
        idle(2);
        check("t2_err_none", err_cnt - e0, 0);

        // Nine digits: error on the ninth, trailing LF is harmless
        e0 = err_cnt; s0 = stb_cnt;
        send_str("W12345678");
        check("t3_8dig_no_err", err_cnt - e0, 0);
        send_str("9");
        check("t3_9th_digit_err", err_cnt - e0, 1);
        send_byte(8'h0A);
        idle(2);
        check("t3_lf_no_err", err_cnt - e0, 1);
        check("t3_no_stb", stb_cnt - s0, 0);

        // Bad digit: 'x' aborts, then 'y' and 'z' are junk in IDLE
        e0 = err_cnt;
        send_str("Wx");
        check("t3_x_err", err_cnt - e0, 1);
        send_str("yz");
        send_byte(8'h0A);
        check("t3_xyz_errs", err_cnt - e0, 3);

        // Missing / surplus payload
        e0 = err_cnt;
        send_str("W");
        send_byte(8'h0A);
        check("t3_w_empty_err", err_cnt - e0, 1);
        send_str("S5");
        send_byte(8'h0A);
        idle(2);
        check("t3_s_data_err", err_cnt - e0, 2);
        check("t3_no_stb_all", stb_cnt - s0, 0);

        // Backpressure: word waits in PEND, bytes received meanwhile are dropped
        i_busy = 1'b1;
        s0 = stb_cnt;
        send_str("W5");
        send_byte(8'h0A);
        idle(3);
        check("t4_dw_busy", o_dw_busy, 1);
        check("t4_no_stb_busy", stb_cnt - s0, 0);
        e0 = err_cnt;
        send_str("R");
        check("t4_rx_in_pend_err", err_cnt - e0, 1);
        check("t4_still_pending", o_dw_busy, 1);
        expect_word(34'h1_0000_0005, 1'b1);
        i_busy = 1'b0;
        idle(1);
        check("t4_stb_next_clk", o_stb, 1);
        idle(1);
        check("t4_dw_busy_clear", o_dw_busy, 0);

        // Timeout after 16 idle clocks inside a frame
        e0 = err_cnt;
        send_str("W12");
        idle(14);
        check("t5_no_early_timeout", err_cnt - e0, 0);
        idle(1);
        check("t5_timeout_err", o_err, 1);
        idle(1);
        expect_word(34'h1_0000_0003, 1'b1);
        send_str("W3");
        send_byte(8'h0A);
        idle(2);
        check("t5_err_once", err_cnt - e0, 1);

        // Asynchronous reset mid-frame
        send_str("W1");
        i_reset = 1'b1;
        #1;
        check("t6_word_cleared", o_word, 0);
        check("t6_we_cleared", o_wb_we, 0);
        check("t6_dw_busy", o_dw_busy, 0);
        idle(2);
        i_reset = 1'b0;
        idle(1);
        e0 = err_cnt;
        expect_word(34'h3_0000_0000, 1'b0);
        send_str("S");
        send_byte(8'h0A);
        idle(2);
        check("t6_no_err_after_reset", err_cnt - e0, 0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
